// File: rtl/uart_pkg.sv
// Shared state encoding, width defaults and sizing helpers for the UART TX arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_LOAD = 2'b01,
    ARB_WAIT = 2'b11
  } arb_state_e;

  localparam int DEF_DATA_W = 8;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Index fields stay at least one bit wide even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping
// past NUM_REQ-1 back to 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    win,
  output logic               valid
);

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      win   = req[(int'(rr_ptr) + i) % NUM_REQ] ? ID_W'((int'(rr_ptr) + i) % NUM_REQ) : win;
      valid = valid | req[(int'(rr_ptr) + i) % NUM_REQ];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX engine among NUM_REQ byte producers.
// Define ARB_BURST_EN to let one requester keep the engine for up to BURST_MAX bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W
`ifdef ARB_BURST_EN
  ,
  parameter int BURST_MAX = 4
`endif
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic                          tx_done,
  output logic                          tx_load,
  output logic [DATA_W-1:0]             tx_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
  output logic                          busy
);

  localparam int              ID_W    = id_width(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                tx_load_q, tx_load_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     pick_id;
  logic                pick_valid;

`ifdef ARB_BURST_EN
  localparam int               CNT_W      = clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
`endif

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + ID_W'(1'b1);
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .win    (pick_id),
    .valid  (pick_valid)
  );

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tx_load_d  = 1'b0;
    tx_data_d  = tx_data_q;
    ack_d      = '0;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
`ifdef ARB_BURST_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
`ifdef ARB_BURST_EN
        // A burst ends early once its owner stops requesting; scanning from the
        // owner's slot with its req low already lands on the next requester.
        if ((burst_cnt_q != '0) && !req[rr_ptr_q]) begin
          rr_ptr_d    = next_id(rr_ptr_q);
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
`endif
        if (pick_valid) begin
          tx_data_d  = req_data[int'(pick_id)*DATA_W +: DATA_W];
          grant_id_d = pick_id;
          ack_d      = NUM_REQ'(1'b1) << pick_id;
          tx_load_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = ARB_LOAD;
        end else begin
          busy_d  = 1'b0;
          state_d = ARB_IDLE;
        end
      end
      ARB_LOAD: begin
`ifdef ARB_BURST_EN
        if (burst_cnt_q >= BURST_LAST) begin
          rr_ptr_d    = next_id(grant_id_q);
          burst_cnt_d = '0;
        end else begin
          rr_ptr_d    = grant_id_q;
          burst_cnt_d = burst_cnt_q + CNT_W'(1'b1);
        end
`else
        rr_ptr_d = next_id(grant_id_q);
`endif
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (tx_done) begin
          busy_d  = 1'b0;
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      tx_load_q  <= 1'b0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
`ifdef ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_load_q  <= tx_load_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
`ifdef ARB_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  assign tx_load  = tx_load_q;
  assign tx_data  = tx_data_q;
  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level round-robin reference model.
module tb_uart_tx_arbiter;

`ifdef ARB_BURST_EN
  localparam int BURST_MAX = 4;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_done;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;

  always #5 clock = ~clock;

  uart_tx_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .tx_done  (tx_done),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  int tx_cnt      = 0;
  int frame_len   = 10;
  int step_no     = 0;
  int done_step   = -100;
  int load_step   = -100;
  int grants[$];

  // Reference model: arbiter availability, round-robin pointer, burst run length.
  int   m_ptr, m_run, m_w;
  bit   m_ready, m_loaded;
  logic       exp_load;
  logic [3:0] exp_ack;
  logic [7:0] exp_data;
  logic [1:0] exp_id;
  logic       exp_busy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic [31:0] d, input logic done,
                            input logic rst);
    if (rst) begin
      m_ptr = 0; m_run = 0; m_ready = 1'b1; m_loaded = 1'b0;
      exp_load = 1'b0; exp_ack = 4'h0; exp_data = 8'h00; exp_id = 2'd0; exp_busy = 1'b0;
      return;
    end
    exp_load = 1'b0;
    exp_ack  = 4'h0;
    if (m_ready) begin
`ifdef ARB_BURST_EN
      if (m_run > 0 && !r[m_ptr]) begin
        m_ptr = (m_ptr + 1) % 4;
        m_run = 0;
      end
`endif
      m_w = -1;
      for (int k = 0; k < 4; k++) if (m_w < 0 && r[(m_ptr + k) % 4]) m_w = (m_ptr + k) % 4;
      if (m_w >= 0) begin
        exp_load = 1'b1;
        exp_ack  = 4'b0001 << m_w;
        exp_data = d[m_w*8 +: 8];
        exp_id   = m_w[1:0];
        exp_busy = 1'b1;
        m_ready  = 1'b0;
        m_loaded = 1'b1;
      end else begin
        exp_busy = 1'b0;
      end
    end else if (m_loaded) begin
      m_loaded = 1'b0;
`ifdef ARB_BURST_EN
      m_run++;
      if (m_run < BURST_MAX) m_ptr = m_w;
      else begin
        m_ptr = (m_w + 1) % 4;
        m_run = 0;
      end
`else
      m_ptr = (m_w + 1) % 4;
`endif
    end else if (done) begin
      exp_busy = 1'b0;
      m_ready  = 1'b1;
    end
  endtask

  // One clock: drive at negedge, advance the TX-engine emulator, check after posedge.
  task automatic step(input logic [3:0] r, input logic [31:0] d, input logic xdone,
                      input logic rst);
    logic dn;
    step_no++;
    dn = xdone;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) dn = 1'b1;
    end
    if (rst) tx_cnt = 0;
    if (dn) done_step = step_no;
    req = r; req_data = d; tx_done = dn; reset = rst;
    model_step(r, d, dn, rst);
    @(posedge clock);
    #1;
    check_eq("tx_load", tx_load, exp_load);
    check_eq("ack", ack, exp_ack);
    check_eq("tx_data", tx_data, exp_data);
    check_eq("grant_id", grant_id, exp_id);
    check_eq("busy", busy, exp_busy);
    if (tx_load === 1'b1) begin
      grants.push_back(grant_id);
      load_step = step_no;
      tx_cnt = frame_len;
    end
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  r_cur;
    logic [31:0] d_cur;
`ifdef ARB_BURST_EN
    int exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
    int exp_seq[4] = '{0, 1, 0, 1};
`endif
    req = 4'h0; req_data = 32'h0; tx_done = 1'b0; reset = 1'b1;
    @(negedge clock);
    step(4'h0, 32'h0, 1'b0, 1'b1);
    step(4'h0, 32'h0, 1'b0, 1'b1);
    check_eq("rst_tx_load", tx_load, 32'd0);
    check_eq("rst_ack", ack, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_grant_id", grant_id, 32'd0);
    check_eq("rst_tx_data", tx_data, 32'd0);

    // Single request from requester 2.
    grants.delete();
    step(4'b0100, 32'h00A5_0000, 1'b0, 1'b0);
    check_eq("single_load", tx_load, 32'd1);
    check_eq("single_ack", ack, 32'h4);
    check_eq("single_data", tx_data, 32'hA5);
    check_eq("single_id", grant_id, 32'd2);
    for (int i = 0; i < 14; i++) step(4'h0, 32'h00A5_0000, 1'b0, 1'b0);
    check_eq("single_loads", grants.size(), 32'd1);
    check_eq("single_busy_end", busy, 32'd0);

    // All four requesting continuously, 10-cycle frames.
    step(4'h0, 32'h0, 1'b0, 1'b1);
    grants.delete();
    frame_len = 10;
    d = 32'h4433_2211;
    for (int i = 0; i < 200 && grants.size() < 5; i++) begin
      step(4'hF, d, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) if (ack[k]) d[k*8 +: 8] = 8'($urandom);
    end
    check_eq("rr4_count", grants.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      check_eq("rr4_order", (i < grants.size()) ? grants[i] : 32'hFF, i % 4);

    // Request arriving mid-frame waits; done in cycle n gives the load in cycle n+2,
    // which is observed one step after the step that drove tx_done.
    step(4'h0, 32'h0, 1'b0, 1'b1);
    grants.delete();
    step(4'b0001, 32'h0000_0033, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step((i >= 3) ? 4'b1000 : 4'b0000, 32'h7700_0033, 1'b0, 1'b0);
      if (tx_load === 1'b1) break;
    end
    check_eq("mid_loads", grants.size(), 32'd2);
    check_eq("mid_gap", load_step - done_step, 32'd1);
    check_eq("mid_id", grant_id, 32'd3);
    check_eq("mid_data", tx_data, 32'h77);

    // Spurious tx_done in IDLE, then reset while waiting for the frame.
    step(4'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'h0, 32'h0, 1'b1, 1'b0);
    check_eq("spur_busy", busy, 32'd0);
    step(4'b0100, 32'h0055_0000, 1'b0, 1'b0);
    check_eq("spur_then_id", grant_id, 32'd2);
    step(4'h0, 32'h0, 1'b0, 1'b0);
    step(4'h0, 32'h0, 1'b0, 1'b0);
    check_eq("wait_busy", busy, 32'd1);
    step(4'h0, 32'h0, 1'b0, 1'b1);
    check_eq("midrst_busy", busy, 32'd0);
    check_eq("midrst_id", grant_id, 32'd0);
    check_eq("midrst_data", tx_data, 32'd0);
    step(4'b1001, 32'h6600_0011, 1'b0, 1'b0);
    check_eq("midrst_ack", ack, 32'h1);

    // tx_done coincident with req[1] rising.
    step(4'h0, 32'h0, 1'b0, 1'b1);
    step(4'b0001, 32'h0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 20 && tx_cnt != 1; i++) step(4'h0, 32'h0, 1'b0, 1'b0);
    step(4'b0010, 32'h0000_BB00, 1'b0, 1'b0);
    check_eq("coinc_idle_load", tx_load, 32'd0);
    step(4'b0010, 32'h0000_BB00, 1'b0, 1'b0);
    check_eq("coinc_load", tx_load, 32'd1);
    check_eq("coinc_id", grant_id, 32'd1);

    // Requesters 0 and 1 held high: burst or plain alternation.
    step(4'h0, 32'h0, 1'b0, 1'b1);
    grants.delete();
    frame_len = 3;
    d = 32'h0000_2010;
    for (int i = 0; i < 300 && grants.size() < $size(exp_seq); i++) begin
      step(4'b0011, d, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) if (ack[k]) d[k*8 +: 8] = 8'($urandom);
    end
    check_eq("hold_count", grants.size(), $size(exp_seq));
    for (int i = 0; i < $size(exp_seq); i++)
      check_eq("hold_order", (i < grants.size()) ? grants[i] : 32'hFF, exp_seq[i]);

    // Randomized traffic with contract-abiding requesters and occasional resets.
    step(4'h0, 32'h0, 1'b0, 1'b1);
    r_cur = 4'h0;
    d_cur = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      logic rst_now;
      logic xd;
      rst_now = ($urandom_range(299, 0) == 0);
      xd = (tx_cnt == 0) && ($urandom_range(7, 0) == 0);
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          if ($urandom_range(1, 0) == 1) r_cur[i] = 1'b0;
          else d_cur[i*8 +: 8] = 8'($urandom);
        end else if (!r_cur[i]) begin
          if ($urandom_range(5, 0) == 0) begin
            r_cur[i] = 1'b1;
            d_cur[i*8 +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(39, 0) == 0) begin
          r_cur[i] = 1'b0;
        end
      end
      frame_len = $urandom_range(8, 2);
      step(r_cur, d_cur, xd, rst_now);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
